// File: rtl/uart_pkg.sv
// UART shared definitions: FSM state encoding and bit-timing helpers.
// Used by both the receive and transmit paths.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        BREAK
    } uart_state_e;

    localparam int CLKS_PER_BIT_DFLT = 868;
    localparam int HALF_BIT          = CLKS_PER_BIT_DFLT / 2;
    localparam int CNT_W             = $clog2(CLKS_PER_BIT_DFLT);

    function automatic int half_bit(input int cpb);
        return cpb / 2;
    endfunction

    function automatic int cnt_w(input int cpb);
        return $clog2(cpb);
    endfunction

endpackage

// File: rtl/uart_rx_read_buff.sv
// Single-entry valid/ready holding buffer for received words.
// A push into a full, non-draining buffer is dropped and flagged.
module read_buff #(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  i_push,
    input  logic [DATA_WIDTH-1:0] i_word,
    input  logic                  i_ready,
    output logic [DATA_WIDTH-1:0] o_data,
    output logic                  o_valid,
    output logic                  o_overrun
);

    logic [DATA_WIDTH-1:0] r_data;
    logic                  r_valid;
    logic                  r_overrun;
    logic                  w_hs;

    assign w_hs = r_valid & i_ready;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_data    <= '0;
            r_valid   <= 1'b0;
            r_overrun <= 1'b0;
        end else begin
            r_overrun <= 1'b0;
            if (i_push) begin
                // A draining buffer can take the new word with no bubble
                if (!r_valid || w_hs) begin
                    r_data  <= i_word;
                    r_valid <= 1'b1;
                end else begin
                    r_overrun <= 1'b1;
                end
            end else if (w_hs) begin
                r_valid <= 1'b0;
            end
        end
    end

    assign o_data    = r_data;
    assign o_valid   = r_valid;
    assign o_overrun = r_overrun;

endmodule

// File: rtl/uart_rx_read.sv
// UART receiver: synchroniser, frame FSM and single-entry read buffer.
// Frames are LSB first with one start and one stop bit.
module uart_rx_read
    import uart_pkg::*;
#(
    parameter int DATA_WIDTH   = 8,
    parameter int CLKS_PER_BIT = 868
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  rx_i,
    output logic [DATA_WIDTH-1:0] data_o,
    output logic                  valid_out,
    input  logic                  ready_out,
    output logic                  frame_err,
    output logic                  overrun,
    output logic                  busy
);

    localparam int L_CNT_W = cnt_w(CLKS_PER_BIT);
    localparam int L_BIT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

    localparam logic [L_CNT_W-1:0] L_HALF_LAST =
        L_CNT_W'(half_bit(CLKS_PER_BIT) - 1);
    localparam logic [L_CNT_W-1:0] L_BIT_LAST =
        L_CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [L_BIT_W-1:0] L_IDX_LAST =
        L_BIT_W'(DATA_WIDTH - 1);

    uart_state_e           r_state;
    uart_state_e           w_state_nx;
    logic                  r_s1;
    logic                  r_rxs;
    logic [L_CNT_W-1:0]    r_cnt;
    logic [L_CNT_W-1:0]    w_cnt_nx;
    logic [L_BIT_W-1:0]    r_bit;
    logic [L_BIT_W-1:0]    w_bit_nx;
    logic [DATA_WIDTH-1:0] r_shift;
    logic [DATA_WIDTH-1:0] w_shift_nx;
    logic                  r_ferr;
    logic                  w_ferr;
    logic                  w_push;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_s1  <= 1'b1;
            r_rxs <= 1'b1;
        end else begin
            r_s1  <= rx_i;
            r_rxs <= r_s1;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_bit   <= '0;
            r_shift <= '0;
            r_ferr  <= 1'b0;
        end else begin
            r_state <= w_state_nx;
            r_cnt   <= w_cnt_nx;
            r_bit   <= w_bit_nx;
            r_shift <= w_shift_nx;
            r_ferr  <= w_ferr;
        end
    end

    always_comb begin
        w_state_nx = r_state;
        w_cnt_nx   = r_cnt;
        w_bit_nx   = r_bit;
        w_shift_nx = r_shift;
        w_push     = 1'b0;
        w_ferr     = 1'b0;
        unique case (r_state)
            IDLE: begin
                if (!r_rxs) begin
                    w_state_nx = START;
                    w_cnt_nx   = '0;
                end
            end
            START: begin
                if (r_cnt == L_HALF_LAST) begin
                    w_cnt_nx = '0;
                    if (!r_rxs) begin
                        w_state_nx = DATA;
                        w_bit_nx   = '0;
                    end else begin
                        w_state_nx = IDLE;
                    end
                end else begin
                    w_cnt_nx = r_cnt + 1'b1;
                end
            end
            DATA: begin
                if (r_cnt == L_BIT_LAST) begin
                    w_cnt_nx          = '0;
                    w_shift_nx[r_bit] = r_rxs;
                    if (r_bit == L_IDX_LAST) begin
                        w_state_nx = STOP;
                    end else begin
                        w_bit_nx = r_bit + 1'b1;
                    end
                end else begin
                    w_cnt_nx = r_cnt + 1'b1;
                end
            end
            STOP: begin
                if (r_cnt == L_BIT_LAST) begin
                    w_cnt_nx = '0;
                    if (r_rxs) begin
                        w_push     = 1'b1;
                        w_state_nx = IDLE;
                    end else begin
                        w_ferr     = 1'b1;
                        w_state_nx = BREAK;
                    end
                end else begin
                    w_cnt_nx = r_cnt + 1'b1;
                end
            end
            BREAK: begin
                // Held-low line: one flag only, resume on the next high
                if (r_rxs) begin
                    w_state_nx = IDLE;
                end
            end
            default: begin
                w_state_nx = IDLE;
            end
        endcase
    end

    read_buff #(
        .DATA_WIDTH(DATA_WIDTH)
    ) u_read_buff (
        .clk      (clk),
        .rstn     (rstn),
        .i_push   (w_push),
        .i_word   (r_shift),
        .i_ready  (ready_out),
        .o_data   (data_o),
        .o_valid  (valid_out),
        .o_overrun(overrun)
    );

    assign frame_err = r_ferr;
    assign busy      = (r_state != IDLE);

endmodule
